// File: rtl/scie_fir_pkg.sv
// rtl/scie_fir_pkg.sv - shared opcodes and FSM state type for the multi-channel SCIE FIR
package scie_fir_pkg;

   localparam logic [6:0] OP_SETCOEF = 7'h0B;
   localparam logic [6:0] OP_PUSH    = 7'h2B;
   localparam logic [6:0] OP_READ    = 7'h5B;
   localparam logic [6:0] OP_CLEAR   = 7'h7B;

   typedef enum logic {
      IDLE = 1'b0,
      MAC  = 1'b1
   } state_e;

endpackage

// File: rtl/scie_fir_mac.sv
// rtl/scie_fir_mac.sv - registered multiply-accumulate; signed saturating when SCIE_FIR_SAT_EN is defined
module scie_fir_mac #(
   parameter int DATA_W = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              clr,
   input  logic              en,
   input  logic [DATA_W-1:0] coef,
   input  logic [DATA_W-1:0] samp,
   output logic [DATA_W-1:0] sum
);

   logic [DATA_W-1:0] acc_q, acc_d;

`ifdef SCIE_FIR_SAT_EN
   localparam logic signed [2*DATA_W:0] SAT_MAX = {{(DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [2*DATA_W:0] SAT_MIN = {{(DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

   logic signed [DATA_W-1:0]   coef_s, samp_s, acc_s;
   logic signed [2*DATA_W-1:0] prod_w;
   logic signed [2*DATA_W:0]   sum_w;

   // Full-width signed product added to the running sum, then clamped to DATA_W range
   always_comb begin
      coef_s = coef;
      samp_s = samp;
      acc_s  = acc_q;
      prod_w = coef_s * samp_s;
      sum_w  = acc_s + prod_w;
      if (sum_w > SAT_MAX) begin
         sum = SAT_MAX[DATA_W-1:0];
      end else if (sum_w < SAT_MIN) begin
         sum = SAT_MIN[DATA_W-1:0];
      end else begin
         sum = sum_w[DATA_W-1:0];
      end
   end
`else
   logic [DATA_W-1:0] prod;

   // Unsigned product truncated to DATA_W; accumulation wraps
   always_comb begin
      prod = coef * samp;
      sum  = acc_q + prod;
   end
`endif

   // Clear wins over enable so a new PUSH always starts from zero
   always_comb begin
      acc_d = acc_q;
      if (clr) begin
         acc_d = '0;
      end else if (en) begin
         acc_d = sum;
      end
   end

   // Accumulator register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

endmodule

// File: rtl/scie_fir_mc.sv
// rtl/scie_fir_mc.sv - multi-channel time-shared FIR custom-instruction unit (option: SCIE_FIR_SAT_EN)
module scie_fir_mc
   import scie_fir_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int TAPS     = 5,
   parameter int CHANNELS = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              io_valid,
   output logic              io_ready,
   input  logic [31:0]       io_insn,
   input  logic [DATA_W-1:0] io_rs1,
   input  logic [DATA_W-1:0] io_rs2,
   output logic [DATA_W-1:0] io_rd,
   output logic              io_busy
);

   localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int TAP_W = $clog2(TAPS);
   localparam logic [DATA_W-1:0] TAPS_LIM = DATA_W'(TAPS);
   localparam logic [DATA_W-1:0] CH_LIM   = DATA_W'(CHANNELS);
   localparam logic [TAP_W-1:0]  K_LAST   = TAP_W'(TAPS - 1);

   state_e            state_q, state_d;
   logic [TAP_W-1:0]  k_q, k_d;
   logic [CH_W-1:0]   ch_q, ch_d;
   logic [DATA_W-1:0] rd_q, rd_d;
   logic [DATA_W-1:0] coef_q [TAPS];
   logic [DATA_W-1:0] coef_d [TAPS];
   logic [DATA_W-1:0] x_q    [CHANNELS][TAPS];
   logic [DATA_W-1:0] x_d    [CHANNELS][TAPS];
   logic [DATA_W-1:0] res_q  [CHANNELS];
   logic [DATA_W-1:0] res_d  [CHANNELS];

   logic              accept;
   logic [6:0]        opcode;
   logic [CH_W-1:0]   ch_sel;
   logic [TAP_W-1:0]  tap_sel;
   logic              mac_clr, mac_en;
   logic [DATA_W-1:0] mac_coef, mac_samp, mac_sum;
   logic              unused_insn;

   assign unused_insn = ^io_insn[31:7];
   assign io_ready    = (state_q == IDLE);
   assign io_busy     = ~io_ready;
   assign io_rd       = rd_q;

   // Command decode, delay-line shift and MAC sequencing; one tap per cycle while busy
   always_comb begin
      state_d  = state_q;
      k_d      = k_q;
      ch_d     = ch_q;
      rd_d     = rd_q;
      coef_d   = coef_q;
      x_d      = x_q;
      res_d    = res_q;
      mac_clr  = 1'b0;
      mac_en   = 1'b0;
      accept   = io_valid && (state_q == IDLE);
      opcode   = io_insn[6:0];
      ch_sel   = io_rs2[CH_W-1:0];
      tap_sel  = io_rs2[TAP_W-1:0];
      mac_coef = coef_q[k_q];
      mac_samp = x_q[ch_q][k_q];

      if (state_q == MAC) begin
         mac_en = 1'b1;
         if (k_q == K_LAST) begin
            res_d[ch_q] = mac_sum;
            state_d     = IDLE;
            k_d         = '0;
         end else begin
            k_d = k_q + 1'b1;
         end
      end else if (accept) begin
         case (opcode)
            OP_SETCOEF: begin
               if (io_rs2 < TAPS_LIM) begin
                  coef_d[tap_sel] = io_rs1;
               end
            end
            OP_PUSH: begin
               if (io_rs2 < CH_LIM) begin
                  for (int k = TAPS - 1; k > 0; k--) begin
                     x_d[ch_sel][k] = x_q[ch_sel][k-1];
                  end
                  x_d[ch_sel][0] = io_rs1;
                  ch_d           = ch_sel;
                  k_d            = '0;
                  state_d        = MAC;
                  mac_clr        = 1'b1;
               end
            end
            OP_READ: begin
               rd_d = (io_rs2 < CH_LIM) ? res_q[ch_sel] : '0;
            end
            OP_CLEAR: begin
               for (int c = 0; c < CHANNELS; c++) begin
                  if (io_rs2[DATA_W-1] || (io_rs2 == DATA_W'(c))) begin
                     res_d[c] = '0;
                     for (int k = 0; k < TAPS; k++) begin
                        x_d[c][k] = '0;
                     end
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   // All architectural state; reset aborts any MAC in flight without writing a result
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         k_q     <= '0;
         ch_q    <= '0;
         rd_q    <= '0;
         for (int k = 0; k < TAPS; k++) begin
            coef_q[k] <= '0;
         end
         for (int c = 0; c < CHANNELS; c++) begin
            res_q[c] <= '0;
            for (int k = 0; k < TAPS; k++) begin
               x_q[c][k] <= '0;
            end
         end
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         ch_q    <= ch_d;
         rd_q    <= rd_d;
         coef_q  <= coef_d;
         x_q     <= x_d;
         res_q   <= res_d;
      end
   end

   scie_fir_mac #(
      .DATA_W (DATA_W)
   ) u_mac (
      .clock (clock),
      .reset (reset),
      .clr   (mac_clr),
      .en    (mac_en),
      .coef  (mac_coef),
      .samp  (mac_samp),
      .sum   (mac_sum)
   );

endmodule
